// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle for the shared bitwise logic unit.
// The master side is the issue logic; the slave side is the arbiter.
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_id;

  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id,
    input  grant_cnt0, grant_cnt1
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id,
    output grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (NOT/AND/OR/XOR) between two
// requesters, with a single registered response slot that supports backpressure.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                  clock,
  input logic                  reset,
  logic_unit_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  localparam logic [1:0] OpNot = 2'b00;
  localparam logic [1:0] OpAnd = 2'b01;
  localparam logic [1:0] OpOr  = 2'b10;
  localparam logic [1:0] OpXor = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic             slot_free;
  logic             grant_id;
  logic             ready0;
  logic             ready1;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] result;

  always_comb begin
    slot_free = (state_q == StEmpty) || bus.resp_ready;

    // Contention resolves to the pointer holder; a lone requester always wins.
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = prio_q;
    end else begin
      grant_id = bus.req1_valid;
    end

    // Readies are held low for the whole time reset is asserted, not just at edges.
    ready0 = reset && slot_free && !grant_id && bus.req0_valid;
    ready1 = reset && slot_free &&  grant_id && bus.req1_valid;
    accept = ready0 || ready1;
  end

  always_comb begin
    sel_op = grant_id ? bus.req1_op : bus.req0_op;
    sel_a  = grant_id ? bus.req1_a  : bus.req0_a;
    sel_b  = grant_id ? bus.req1_b  : bus.req0_b;

    result = '0;
    unique case (sel_op)
      OpNot:   result = ~sel_a;
      OpAnd:   result = sel_a & sel_b;
      OpOr:    result = sel_a | sel_b;
      OpXor:   result = sel_a ^ sel_b;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    prio_d  = prio_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (accept) begin
          state_d = StFull;
        end else if (bus.resp_ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      data_d = result;
      id_d   = grant_id;
      prio_d = ~grant_id;
    end

    if (ready0 && (cnt0_q != '1)) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (ready1 && (cnt1_q != '1)) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.resp_valid = (state_q == StFull);
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = id_q;
  assign bus.grant_cnt0 = cnt0_q;
  assign bus.grant_cnt1 = cnt1_q;

endmodule
